morra_scoreboard: RTL



---
 rtl/morra_pkg.sv | 37 +++
 rtl/morra_scoreboard_sat_counter.sv | 32 +++
 rtl/morra_scoreboard.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/morra_pkg.sv
// Shared codes, widths and state enum for the Morra Cinese game
// and its scoreboard.
package morra_pkg;

  localparam int RND_W   = 5;
  localparam int MATCH_W = 8;

  typedef enum logic [1:0] {
    ROUND_NONE = 2'b00,
    ROUND_P1   = 2'b01,
    ROUND_P2   = 2'b10,
    ROUND_TIE  = 2'b11
  } round_e;

  typedef enum logic [1:0] {
    GAME_RUN  = 2'b00,
    GAME_P1   = 2'b01,
    GAME_P2   = 2'b10,
    GAME_DRAW = 2'b11
  } game_e;

  typedef enum logic [1:0] {
    SB_IDLE    = 2'b00,
    SB_PLAYING = 2'b01,
    SB_DONE    = 2'b10
  } sb_state_e;

  function automatic logic [RND_W-1:0] sat_add1(
    input logic [RND_W-1:0] v,
    input logic             inc
  );
    if (inc && (v != {RND_W{1'b1}}))
      return v + RND_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/morra_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Synchronous active-low reset.
module sat_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (inc && (q_q != {W{1'b1}}))
      q_d = q_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/morra_scoreboard.sv
// Morra scoreboard: per-match round stats, lifetime totals and a
// valid/ready result record. Option: MORRA_SCOREBOARD_HISTORY_EN.
module morra_scoreboard
  import morra_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         round,
  input  logic [1:0]         game,
  output logic [RND_W-1:0]   p1_wins,
  output logic [RND_W-1:0]   p2_wins,
  output logic [RND_W-1:0]   ties,
  output logic [RND_W-1:0]   invalid,
  output logic [RND_W-1:0]   played,
  output logic [MATCH_W-1:0] p1_matches,
  output logic [MATCH_W-1:0] p2_matches,
  output logic [MATCH_W-1:0] draws,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [1:0]         result_winner,
  output logic [RND_W-1:0]   result_rounds,
  output logic               result_lost
`ifdef MORRA_SCOREBOARD_HISTORY_EN
  ,output logic [31:0]       history
`endif
);

  sb_state_e        state_q, state_d;
  logic [1:0]       winner_q, winner_d;
  logic [RND_W-1:0] rounds_q, rounds_d;
  logic             lost_q, lost_d;

  logic play, rnd_valid, match_end;
  logic inc_p1, inc_p2, inc_tie, inc_inv;
  logic end_p1, end_p2, end_draw;

  assign play      = (state_q == SB_PLAYING) && !start;
  assign rnd_valid = (round != ROUND_NONE);
  assign match_end = play && (game != GAME_RUN);

  // Decode the sampled round and final game code into counter strobes.
  always_comb begin
    inc_p1   = 1'b0;
    inc_p2   = 1'b0;
    inc_tie  = 1'b0;
    inc_inv  = 1'b0;
    end_p1   = 1'b0;
    end_p2   = 1'b0;
    end_draw = 1'b0;
    if (play) begin
      unique case (1'b1)
        round == ROUND_P1:   inc_p1  = 1'b1;
        round == ROUND_P2:   inc_p2  = 1'b1;
        round == ROUND_TIE:  inc_tie = 1'b1;
        round == ROUND_NONE: inc_inv = 1'b1;
      endcase
    end
    if (match_end) begin
      unique case (1'b1)
        game == GAME_P1:   end_p1   = 1'b1;
        game == GAME_P2:   end_p2   = 1'b1;
        game == GAME_DRAW: end_draw = 1'b1;
        default: ;
      endcase
    end
  end

  // Next state, result payload latch and lost-record flag.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rounds_d = rounds_q;
    lost_d   = lost_q;
    if (start) begin
      state_d = SB_PLAYING;
      if ((state_q == SB_DONE) && !result_ready)
        lost_d = 1'b1;
    end else begin
      unique case (state_q)
        SB_IDLE: ;
        SB_PLAYING: begin
          if (game != GAME_RUN) begin
            winner_d = game;
            rounds_d = sat_add1(played, rnd_valid);
            state_d  = SB_DONE;
          end
        end
        SB_DONE: begin
          if (result_ready)
            state_d = SB_IDLE;
        end
        default: state_d = SB_IDLE;
      endcase
    end
  end

  // State and result record registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SB_IDLE;
      winner_q <= '0;
      rounds_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rounds_q <= rounds_d;
      lost_q   <= lost_d;
    end
  end

  assign result_valid  = (state_q == SB_DONE);
  assign result_winner = winner_q;
  assign result_rounds = rounds_q;
  assign result_lost   = lost_q;

  sat_counter #(.W(RND_W)) u_p1 (
    .clk(clk), .rst_n(rst_n), .clr(start),
    .inc(inc_p1), .q(p1_wins));
  sat_counter #(.W(RND_W)) u_p2 (
    .clk(clk), .rst_n(rst_n), .clr(start),
    .inc(inc_p2), .q(p2_wins));
  sat_counter #(.W(RND_W)) u_tie (
    .clk(clk), .rst_n(rst_n), .clr(start),
    .inc(inc_tie), .q(ties));
  sat_counter #(.W(RND_W)) u_inv (
    .clk(clk), .rst_n(rst_n), .clr(start),
    .inc(inc_inv), .q(invalid));
  sat_counter #(.W(RND_W)) u_played (
    .clk(clk), .rst_n(rst_n), .clr(start),
    .inc(play && rnd_valid), .q(played));

  sat_counter #(.W(MATCH_W)) u_p1m (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .inc(end_p1), .q(p1_matches));
  sat_counter #(.W(MATCH_W)) u_p2m (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .inc(end_p2), .q(p2_matches));
  sat_counter #(.W(MATCH_W)) u_draw (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .inc(end_draw), .q(draws));

`ifdef MORRA_SCOREBOARD_HISTORY_EN
  logic [31:0] hist_q, hist_d;

  // Round-code history, newest code in the low bits.
  always_comb begin
    hist_d = hist_q;
    if (start)
      hist_d = '0;
    else if (play)
      hist_d = {hist_q[29:0], round};
  end

  // History register.
  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= hist_d;
  end

  assign history = hist_q;
`endif

endmodule
